// File: rtl/wallace_seq_mult.sv
// wallace_seq_mult: WIDTH x WIDTH multiplier using one row of TILE x TILE tile products per clock (optional WMUL_SIGNED_EN adds is_signed).
// Latency: out_valid rises ROWS edges after the accepting edge; one product per ROWS+2 cycles at best.
// Backpressure: in_ready only while IDLE; the product is held in DONE until out_ready.
module wallace_seq_mult #(
    parameter int WIDTH = 32,
    parameter int TILE  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef WMUL_SIGNED_EN
    input  logic                 is_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);
    localparam int ROWS = WIDTH / TILE;
    localparam int KW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int RW   = WIDTH + TILE;
    localparam int PW   = 2 * WIDTH;

    generate
        if ((WIDTH % TILE) != 0) begin : g_bad_width
            $error("wallace_seq_mult: WIDTH must be a multiple of TILE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [KW-1:0]     k;
    logic [PW-1:0]     acc;
    logic [TILE-1:0]   b_dig;
    logic [2*TILE-1:0] tile;
    logic [RW-1:0]     row;
    logic [PW-1:0]     row_sh, sum, prod;
    logic              last_row;

    assign in_ready = (state == IDLE);
    assign last_row = (k == KW'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last_row)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // One row: a_reg times the current B digit, as a sum of shifted tile products.
    always_comb begin
        b_dig = b_reg[k*TILE +: TILE];
        tile  = '0;
        row   = '0;
        for (int j = 0; j < ROWS; j++) begin
            tile = {{TILE{1'b0}}, a_reg[j*TILE +: TILE]} * {{TILE{1'b0}}, b_dig};
            row  = row + (RW'(tile) << (j*TILE));
        end
        row_sh = PW'(row) << (k*TILE);
        sum    = acc + row_sh;
    end

`ifdef WMUL_SIGNED_EN
    logic neg_reg;

    // Operands are held as magnitudes; the sign is reapplied when p is loaded.
    always_comb begin
        a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
        prod  = neg_reg ? -sum : sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          neg_reg <= 1'b0;
        else if (state == IDLE && in_valid)  neg_reg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
        prod  = sum;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            k         <= '0;
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= a_mag;
                    b_reg <= b_mag;
                    acc   <= '0;
                    k     <= '0;
                end
                CALC: begin
                    acc <= sum;
                    k   <= last_row ? '0 : k + KW'(1);
                    if (last_row) begin
                        p         <= prod;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
